// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and limits for the instruction/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int MEM_LAT_MAX = 15;

endpackage

`default_nettype wire

// File: rtl/mem_lat_counter.sv
// ============================================================================
// Module   : mem_lat_counter
// Brief    : 4-bit loadable down-counter with a zero flag (read latency wait).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign zero = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one fixed-latency memory between fetch and MEM stage.
//            Define ARB_FAIR_EN for round-robin tie breaking (default: data
//            beats fetch).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         c_lat_clamp = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                                       ((MEM_LAT < 1) ? 1 : MEM_LAT);
  localparam logic [3:0] c_lat_load  = 4'(c_lat_clamp - 1);

  arb_state_e r_state;
  arb_state_e w_next;
  owner_e     r_owner;
  logic       r_we;
  logic       w_if_elig;
  logic       w_dm_elig;
  logic       w_grant;
  logic       w_grant_dm;
  logic       w_cnt_load;
  logic       w_cnt_dec;
  logic       w_cnt_zero;

  assign w_if_elig = if_req & ~halt;
  assign w_dm_elig = dm_req;
  assign w_grant   = (r_state == IDLE) & (w_if_elig | w_dm_elig);

`ifdef ARB_FAIR_EN
  // Remembers who won the previous grant; resets to fetch so data takes the first tie.
  logic r_last_dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_dm <= 1'b0;
    end else if (w_grant) begin
      r_last_dm <= w_grant_dm;
    end
  end

  assign w_grant_dm = w_dm_elig & (~w_if_elig | ~r_last_dm);
`else
  assign w_grant_dm = w_dm_elig;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    unique case (r_state)
      IDLE:  if (w_if_elig | w_dm_elig) w_next = ISSUE;
      ISSUE: begin
        w_cnt_load = 1'b1;
        w_next     = r_we ? RESP : WAIT;
      end
      // Reads dwell here MEM_LAT cycles so capture lands on the data-valid cycle.
      WAIT: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) w_next = RESP;
      end
      RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  mem_lat_counter u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (c_lat_load),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      r_we      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      r_state <= w_next;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      // Strobes are set on the grant edge so they are high exactly during ISSUE.
      if (w_grant) begin
        r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
        r_we    <= w_grant_dm & dm_we;
        mem_rd  <= ~(w_grant_dm & dm_we);
        mem_wr  <= w_grant_dm & dm_we;
        if (w_grant_dm) begin
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_addr  <= if_addr;
        end
      end
      if ((r_state == WAIT) && w_cnt_zero) begin
        if (r_owner == OWN_DM) dm_rdata <= mem_rdata;
        else                   if_rdata <= mem_rdata;
      end
    end
  end

  assign if_done  = (r_state == RESP) & (r_owner == OWN_IF);
  assign dm_done  = (r_state == RESP) & (r_owner == OWN_DM);
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule

`default_nettype wire
